// File: rtl/range_xform_pipe.sv
// range_xform_pipe
//   Two-stage range-classify-and-transform stage on a valid/ready stream.
//   Each accepted word is checked against a programmable table of bands. The
//   lowest-index enabled band whose threshold the word strictly exceeds wins.
//   That band's op (pass/add/sub/shl) is then applied to the word.
//
//   Optional build macro: RANGE_XFORM_SAT_EN
//     defined   -> add/sub/shl saturate instead of wrapping
//     undefined -> modulo 2^WIDTH arithmetic, no saturation logic
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data                     upstream handshake + word
//   out_valid/out_ready/out_data/out_band/out_hit downstream handshake + result
//   cfg_we/cfg_idx/cfg_en/cfg_thresh/cfg_op/cfg_operand  band table write port
module range_xform_pipe #(
   parameter int WIDTH     = 8,
   parameter int NUM_BANDS = 8,
   parameter int IDX_W     = $clog2(NUM_BANDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDX_W-1:0] out_band,
   output logic             out_hit,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [WIDTH-1:0] cfg_thresh,
   input  logic [1:0]       cfg_op,
   input  logic [WIDTH-1:0] cfg_operand
);

   localparam logic [1:0]       OP_PASS = 2'd0;
   localparam logic [1:0]       OP_ADD  = 2'd1;
   localparam logic [1:0]       OP_SUB  = 2'd2;
   localparam logic [1:0]       OP_SHL  = 2'd3;
   localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);

   // band table
   logic [NUM_BANDS-1:0]            tbl_en;
   logic [NUM_BANDS-1:0][WIDTH-1:0] tbl_thresh;
   logic [NUM_BANDS-1:0][1:0]       tbl_op;
   logic [NUM_BANDS-1:0][WIDTH-1:0] tbl_operand;

   // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 (output) valid
   logic [2:1] vld_pipe;
   logic       adv;

   // S1 registers
   logic [WIDTH-1:0] s1_data;
   logic             s1_hit;
   logic [IDX_W-1:0] s1_band;
   logic [1:0]       s1_op;
   logic [WIDTH-1:0] s1_operand;

   // winning band for the word currently on in_data
   logic [NUM_BANDS-1:0] band_match;
   logic                 win_hit;
   logic [IDX_W-1:0]     win_band;
   logic [1:0]           win_op;
   logic [WIDTH-1:0]     win_operand;

   logic [WIDTH-1:0] xf_data;

   // The whole pipe moves together; a stalled output freezes both stages.
   assign adv       = !vld_pipe[2] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_pipe[2];

   // Table write. Indices with no matching entry fall through and are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_en      <= '0;
         tbl_thresh  <= '0;
         tbl_op      <= '0;
         tbl_operand <= '0;
      end else if (cfg_we) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            if (cfg_idx == IDX_W'(i)) begin
               tbl_en[i]      <= cfg_en;
               tbl_thresh[i]  <= cfg_thresh;
               tbl_op[i]      <= cfg_op;
               tbl_operand[i] <= cfg_operand;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_BANDS; g++) begin : g_match
      assign band_match[g] = tbl_en[g] && (in_data > tbl_thresh[g]);
   end

   // Priority select: scan high to low so the lowest matching index lands last.
   always_comb begin
      win_hit     = 1'b0;
      win_band    = '0;
      win_op      = OP_PASS;
      win_operand = '0;
      for (int i = NUM_BANDS - 1; i >= 0; i--) begin
         if (band_match[i]) begin
            win_hit     = 1'b1;
            win_band    = IDX_W'(i);
            win_op      = tbl_op[i];
            win_operand = tbl_operand[i];
         end
      end
   end

`ifdef RANGE_XFORM_SAT_EN
   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH:0]       sum_w;
   logic [2*WIDTH-1:0]   shl_w;

   assign sum_w = {1'b0, s1_data} + {1'b0, s1_operand};
   assign shl_w = {{WIDTH{1'b0}}, s1_data} << s1_operand;

   always_comb begin
      xf_data = s1_data;
      case (s1_op)
         OP_ADD: xf_data = sum_w[WIDTH] ? ONES : sum_w[WIDTH-1:0];
         OP_SUB: xf_data = (s1_data < s1_operand) ? '0 : s1_data - s1_operand;
         OP_SHL: begin
            if (s1_operand >= W_VAL)
               xf_data = (s1_data != '0) ? ONES : '0;
            else
               xf_data = (shl_w[2*WIDTH-1:WIDTH] != '0) ? ONES : shl_w[WIDTH-1:0];
         end
         default: xf_data = s1_data;
      endcase
   end
`else
   always_comb begin
      xf_data = s1_data;
      case (s1_op)
         OP_ADD:  xf_data = s1_data + s1_operand;
         OP_SUB:  xf_data = s1_data - s1_operand;
         OP_SHL:  xf_data = (s1_operand >= W_VAL) ? '0 : s1_data << s1_operand;
         default: xf_data = s1_data;
      endcase
   end
`endif

   // S1 captures the op/operand of the winner so later table writes cannot
   // affect words already in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe   <= '0;
         s1_data    <= '0;
         s1_hit     <= 1'b0;
         s1_band    <= '0;
         s1_op      <= OP_PASS;
         s1_operand <= '0;
         out_data   <= '0;
         out_band   <= '0;
         out_hit    <= 1'b0;
      end else if (adv) begin
         vld_pipe[1] <= in_valid;
         vld_pipe[2] <= vld_pipe[1];
         if (in_valid) begin
            s1_data    <= in_data;
            s1_hit     <= win_hit;
            s1_band    <= win_band;
            s1_op      <= win_op;
            s1_operand <= win_operand;
         end
         if (vld_pipe[1]) begin
            out_data <= xf_data;
            out_band <= s1_band;
            out_hit  <= s1_hit;
         end
      end
   end

endmodule

// File: tb/tb_range_xform_pipe.sv
// Self-checking bench for range_xform_pipe (WIDTH=8, NUM_BANDS=8).
// A behavioural model keeps its own copy of the band table and computes each
// expected result with plain integer arithmetic; expected results are queued
// at accept time and compared at output handshake time.
module tb_range_xform_pipe;
   localparam int WIDTH     = 8;
   localparam int NUM_BANDS = 8;
   localparam int IDX_W     = 3;
   localparam int MAXV      = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDX_W-1:0] out_band;
   logic             out_hit;
   logic             cfg_we;
   logic [IDX_W-1:0] cfg_idx;
   logic             cfg_en;
   logic [WIDTH-1:0] cfg_thresh;
   logic [1:0]       cfg_op;
   logic [WIDTH-1:0] cfg_operand;

   range_xform_pipe #(.WIDTH(WIDTH), .NUM_BANDS(NUM_BANDS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_band(out_band), .out_hit(out_hit),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_thresh(cfg_thresh), .cfg_op(cfg_op), .cfg_operand(cfg_operand)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int m_en[NUM_BANDS];
   int m_th[NUM_BANDS];
   int m_op[NUM_BANDS];
   int m_opnd[NUM_BANDS];

   typedef struct {
      int data;
      int band;
      int hit;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t model(input int d);
      exp_t r;
      int   v;
      bit   found;
      r.data = d; r.band = 0; r.hit = 0;
      found = 0;
      for (int i = 0; i < NUM_BANDS; i++) begin
         if (!found && m_en[i] != 0 && d > m_th[i]) begin
            found = 1;
            r.hit = 1;
            r.band = i;
            case (m_op[i])
               1: v = d + m_opnd[i];
               2: v = d - m_opnd[i];
               3: v = (m_opnd[i] >= WIDTH) ? 0 : (d << m_opnd[i]);
               default: v = d;
            endcase
`ifdef RANGE_XFORM_SAT_EN
            if (v > MAXV) v = MAXV;
            if (v < 0) v = 0;
            if (m_op[i] == 3 && m_opnd[i] >= WIDTH && d != 0) v = MAXV;
`else
            v = v & MAXV;
`endif
            r.data = v;
         end
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_BANDS; i++) begin
         m_en[i] = 0; m_th[i] = 0; m_op[i] = 0; m_opnd[i] = 0;
      end
   endtask

   task automatic model_write(input int idx, input int en, input int th, input int op, input int opnd);
      m_en[idx] = en; m_th[idx] = th; m_op[idx] = op; m_opnd[idx] = opnd;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_data = '0; out_ready = 1;
      cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_thresh = '0; cfg_op = '0; cfg_operand = '0;
   endtask

   task automatic drive_cfg(input int idx, input int en, input int th, input int op, input int opnd);
      cfg_we = 1; cfg_idx = IDX_W'(idx); cfg_en = (en != 0);
      cfg_thresh = WIDTH'(th); cfg_op = 2'(op); cfg_operand = WIDTH'(opnd);
   endtask

   // one-cycle table write; the model follows once the edge has passed
   task automatic cfg_write(input int idx, input int en, input int th, input int op, input int opnd);
      drive_cfg(idx, en, th, op, opnd);
      @(posedge clk); #1;
      cfg_we = 0;
      model_write(idx, en, th, op, opnd);
   endtask

   task automatic test_reset();
      rst = 1;
      idle_inputs();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
      checks++; if (out_band !== '0) begin errors++; $display("FAIL reset_out_band got %0d want 0", out_band); end
      checks++; if (out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit got %b want 0", out_hit); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      rst = 0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
   endtask

   task automatic test_table();
      int   words[3];
      exp_t e;
      words[0] = 'hFF; words[1] = 'hF0; words[2] = 'h00;
      cfg_write(0, 1, 'hFE, 3, 1);
      cfg_write(1, 1, 'hF8, 1, 'h0F);
      cfg_write(2, 1, 'hE0, 2, 'h10);
      out_ready = 1;
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            in_valid = 1; in_data = WIDTH'(words[c]);
            exp_q.push_back(model(words[c]));
         end else begin
            in_valid = 0;
         end
         @(posedge clk); #1;
         if (c == 0 || c == 4) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL table_latency c=%0d out_valid got %b want 0", c, out_valid); end
         end else begin
            e = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL table_valid c=%0d got %b want 1", c, out_valid); end
            checks++; if (out_data !== WIDTH'(e.data)) begin errors++; $display("FAIL table_data c=%0d got %h want %h", c, out_data, e.data); end
            checks++; if (out_band !== IDX_W'(e.band)) begin errors++; $display("FAIL table_band c=%0d got %0d want %0d", c, out_band, e.band); end
            checks++; if (out_hit !== 1'(e.hit)) begin errors++; $display("FAIL table_hit c=%0d got %b want %0d", c, out_hit, e.hit); end
         end
      end
      // 0xF0 lands in band 2 and subtracts without borrow in either build
      checks++; if (words[1] - 'h10 != 'hE0 || model('hF0).band != 2) begin errors++; $display("FAIL table_model_band2 got %0d want 2", model('hF0).band); end
   endtask

   task automatic test_saturation();
      exp_t e;
      int   want;
`ifdef RANGE_XFORM_SAT_EN
      want = 'hFF;
`else
      want = 'h09;
`endif
      out_ready = 1;
      in_valid = 1; in_data = 8'hFA;
      e = model('hFA);
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b want 1", out_valid); end
      checks++; if (out_data !== WIDTH'(want)) begin errors++; $display("FAIL sat_data got %h want %h", out_data, want); end
      checks++; if (out_data !== WIDTH'(e.data)) begin errors++; $display("FAIL sat_model got %h want %h", out_data, e.data); end
      checks++; if (out_band !== 3'd1) begin errors++; $display("FAIL sat_band got %0d want 1", out_band); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   n;
      out_ready = 1;
      in_valid = 1; in_data = 8'h10; exp_q.push_back(model('h10));
      @(posedge clk); #1;
      in_data = 8'h20; exp_q.push_back(model('h20));
      @(posedge clk); #1;
      out_ready = 0; in_data = 8'h30;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_drop got %b want 0", in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(exp_q[0].data)) begin
            errors++; $display("FAIL bp_hold c=%0d got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, exp_q[0].data);
         end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold c=%0d got %b want 0", c, in_ready); end
      end
      out_ready = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %b want 1", in_ready); end
      exp_q.push_back(model('h30));
      n = 0;
      while (exp_q.size() > 0 && n < 8) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++; if (out_data !== WIDTH'(e.data) || out_hit !== 1'(e.hit)) begin
               errors++; $display("FAIL bp_order got %h/%b want %h/%0d", out_data, out_hit, e.data, e.hit);
            end
         end
         @(posedge clk); #1;
         in_valid = 0;
         n++;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost got %0d pending want 0", exp_q.size()); exp_q.delete(); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got out_valid %b want 0", out_valid); end
   endtask

   task automatic test_collision();
      exp_t e0, e1, e2;
      out_ready = 1;
      // disable e0 while accepting 0xFF in the same cycle
      drive_cfg(0, 0, 'hFE, 3, 1);
      in_valid = 1; in_data = 8'hFF;
      e0 = model('hFF);
      @(posedge clk); #1;
      cfg_we = 0;
      model_write(0, 0, 'hFE, 3, 1);
      e1 = model('hFF);
      @(posedge clk); #1;
      in_valid = 0;
      checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(e0.data) || out_band !== IDX_W'(e0.band)) begin
         errors++; $display("FAIL coll_old_table got v=%b d=%h b=%0d want v=1 d=%h b=%0d", out_valid, out_data, out_band, e0.data, e0.band);
      end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(e1.data) || out_band !== 3'd1) begin
         errors++; $display("FAIL coll_new_table got v=%b d=%h b=%0d want v=1 d=%h b=1", out_valid, out_data, out_band, e1.data);
      end
`ifndef RANGE_XFORM_SAT_EN
      checks++; if (out_data !== 8'h0E) begin errors++; $display("FAIL coll_wrap got %h want 0e", out_data); end
`endif
      // back-to-back writes to one index: the second must stick
      cfg_write(3, 1, 'h00, 2, 1);
      cfg_write(3, 1, 'h00, 1, 2);
      in_valid = 1; in_data = 8'h05;
      e2 = model('h05);
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      checks++; if (out_data !== WIDTH'(e2.data) || out_band !== 3'd3 || out_hit !== 1'b1) begin
         errors++; $display("FAIL last_write_wins got d=%h b=%0d h=%b want d=%h b=3 h=1", out_data, out_band, out_hit, e2.data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      exp_t e;
      out_ready = 1;
      in_valid = 1; in_data = WIDTH'($urandom_range(1, MAXV));
      @(posedge clk); #1;
      in_data = WIDTH'($urandom_range(1, MAXV));
      @(posedge clk); #1;
      in_valid = 0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_precond got %b want 1", out_valid); end
      #2 rst = 1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", out_valid); end
      checks++; if (out_data !== '0 || out_band !== '0 || out_hit !== 1'b0) begin
         errors++; $display("FAIL arst_outputs got d=%h b=%0d h=%b want 0/0/0", out_data, out_band, out_hit);
      end
      @(posedge clk); #1;
      rst = 0;
      model_clear();
      exp_q.delete();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_flush c=%0d got %b want 0", c, out_valid); end
      end
      in_valid = 1; in_data = 8'hFF;
      e = model('hFF);
      @(posedge clk); #1;
      in_valid = 0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_hit !== 1'b0) begin
         errors++; $display("FAIL arst_cleared_table got v=%b d=%h h=%b want v=1 d=ff h=0", out_valid, out_data, out_hit);
      end
      checks++; if (out_data !== WIDTH'(e.data)) begin errors++; $display("FAIL arst_model got %h want %h", out_data, e.data); end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      exp_t e;
      bit   prev_stall;
      logic [WIDTH-1:0] prev_data;
      logic [IDX_W-1:0] prev_band;
      logic             prev_hit;
      int   op, n;
      for (int i = 0; i < NUM_BANDS; i++) begin
         op = $urandom_range(0, 3);
         cfg_write(i, ($urandom_range(0, 9) < 8) ? 1 : 0, 240 - i * 30 + $urandom_range(0, 14), op,
                   (op == 3) ? $urandom_range(0, 9) : $urandom_range(0, MAXV));
      end
      prev_stall = 0; prev_data = '0; prev_band = '0; prev_hit = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if (prev_stall) begin
            checks++; if (out_valid !== 1'b1 || out_data !== prev_data || out_band !== prev_band || out_hit !== prev_hit) begin
               errors++; $display("FAIL rnd_stall_hold cyc=%0d got v=%b d=%h want v=1 d=%h", cyc, out_valid, out_data, prev_data);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = WIDTH'($urandom_range(0, MAXV));
         if ($urandom_range(0, 9) == 0) begin
            op = $urandom_range(0, 3);
            drive_cfg($urandom_range(0, NUM_BANDS - 1), $urandom_range(0, 1), $urandom_range(0, MAXV), op,
                      (op == 3) ? $urandom_range(0, 10) : $urandom_range(0, MAXV));
         end else begin
            cfg_we = 0;
         end
         #1;
         checks++; if (in_ready !== (!out_valid || out_ready)) begin
            errors++; $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, in_ready, (!out_valid || out_ready));
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rnd_unexpected cyc=%0d got d=%h want no output", cyc, out_data);
            end else begin
               e = exp_q.pop_front();
               if (out_data !== WIDTH'(e.data) || out_band !== IDX_W'(e.band) || out_hit !== 1'(e.hit)) begin
                  errors++; $display("FAIL rnd_result cyc=%0d got d=%h b=%0d h=%b want d=%h b=%0d h=%0d",
                                     cyc, out_data, out_band, out_hit, e.data, e.band, e.hit);
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(int'(in_data)));
         if (cfg_we) model_write(int'(cfg_idx), int'(cfg_en), int'(cfg_thresh), int'(cfg_op), int'(cfg_operand));
         prev_stall = out_valid && !out_ready;
         prev_data = out_data; prev_band = out_band; prev_hit = out_hit;
         @(posedge clk); #1;
      end
      cfg_we = 0; in_valid = 0; out_ready = 1;
      n = 0;
      while (exp_q.size() > 0 && n < 10) begin
         if (out_valid) begin
            e = exp_q.pop_front();
            checks++; if (out_data !== WIDTH'(e.data) || out_band !== IDX_W'(e.band) || out_hit !== 1'(e.hit)) begin
               errors++; $display("FAIL rnd_drain got d=%h want d=%h", out_data, e.data);
            end
         end
         @(posedge clk); #1;
         n++;
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got %0d pending want 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_table();
      test_saturation();
      test_backpressure();
      test_collision();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
